// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: active-low cathode patterns
// {a,b,c,d,e,f,g,dp}, recovered digit codes and the capture FSM encoding.
package seg7_pkg;

  localparam logic [7:0] PAT_0       = 8'h03;
  localparam logic [7:0] PAT_1       = 8'h9F;
  localparam logic [7:0] PAT_2       = 8'h25;
  localparam logic [7:0] PAT_3       = 8'h0D;
  localparam logic [7:0] PAT_4       = 8'h99;
  localparam logic [7:0] PAT_5       = 8'h49;
  localparam logic [7:0] PAT_6       = 8'h41;
  localparam logic [7:0] PAT_7       = 8'h1F;
  localparam logic [7:0] PAT_8       = 8'h01;
  localparam logic [7:0] PAT_9       = 8'h09;
  localparam logic [7:0] PAT_DP_ONLY = 8'hFE;
  localparam logic [7:0] PAT_BLANK   = 8'hFF;

  localparam logic [3:0] CODE_DP    = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hB;
  localparam logic [3:0] CODE_ERR   = 4'hF;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational cathode-pattern to digit-code decoder.
// With SEG7_DP_CAPTURE_EN defined the dp bit is forced off before lookup.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [7:0] i_cathode,
  output logic [3:0] o_code,
  output logic       o_err
);

  logic [7:0] w_pat;

`ifdef SEG7_DP_CAPTURE_EN
  assign w_pat = i_cathode | 8'h01;
`else
  assign w_pat = i_cathode;
`endif

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_code = CODE_ERR;
    o_err  = 1'b0;
    case (w_pat)
      PAT_0:       o_code = 4'h0;
      PAT_1:       o_code = 4'h1;
      PAT_2:       o_code = 4'h2;
      PAT_3:       o_code = 4'h3;
      PAT_4:       o_code = 4'h4;
      PAT_5:       o_code = 4'h5;
      PAT_6:       o_code = 4'h6;
      PAT_7:       o_code = 4'h7;
      PAT_8:       o_code = 4'h8;
      PAT_9:       o_code = 4'h9;
      PAT_DP_ONLY: o_code = CODE_DP;
      PAT_BLANK:   o_code = CODE_BLANK;
      default:     o_err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers digit codes from a multiplexed 7-segment bus and publishes whole
// frames over valid/ready. SEG7_DP_CAPTURE_EN adds per-digit decimal-point capture.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   anode,
  input  logic [7:0]              cathode,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] frame_digits,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic [NUM_DIGITS-1:0]   dp_flags,
  output logic                    overflow
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [NUM_DIGITS-1:0] r_s_an, r_p_an;
  logic [7:0]            r_s_cat, r_p_cat;
  state_e                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [NUM_DIGITS-1:0] r_mask;

  logic [3:0]            r_slot_code [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_slot_err;

  logic                    w_valid, w_same, w_capture, w_full;
  logic [IDX_W-1:0]        w_idx;
  logic [NUM_DIGITS-1:0]   w_cap_bit;
  logic [3:0]              w_code;
  logic                    w_err;
  logic [4*NUM_DIGITS-1:0] w_slot_flat;

  seg7_pattern_decode u_decode (
    .i_cathode (r_s_cat),
    .o_code    (w_code),
    .o_err     (w_err)
  );

  assign w_valid   = ($countones(~r_s_an) == 1);
  assign w_same    = ({r_s_an, r_s_cat} == {r_p_an, r_p_cat});
  assign w_full    = &r_mask;
  assign w_cap_bit = NUM_DIGITS'(1) << w_idx;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!r_s_an[i]) w_idx = IDX_W'(i);
    end
  end

  always_comb begin
    w_slot_flat = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_slot_flat[4*i +: 4] = r_slot_code[i];
    end
  end

  // A fresh valid sample counts as the first stable one; with a dwell of one
  // cycle it is captured straight away.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = SETTLE;
          if (STABLE_CYCLES == 1) begin
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      SETTLE, HOLD: begin
        if (!w_valid) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (!w_same) begin
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = SETTLE;
          if (STABLE_CYCLES == 1) begin
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
          end
        end else if (r_state == SETTLE) begin
          if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s_an  <= '1;
      r_p_an  <= '1;
      r_s_cat <= '1;
      r_p_cat <= '1;
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_s_an  <= anode;
      r_p_an  <= r_s_an;
      r_s_cat <= cathode;
      r_p_cat <= r_s_cat;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: slot storage has no reset; the mask guarantees every slot is
  // written before it is ever published.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_slot_code[w_idx] <= w_code;
      r_slot_err[w_idx]  <= w_err;
    end
  end

`ifdef SEG7_DP_CAPTURE_EN
  logic [NUM_DIGITS-1:0] r_slot_dp;

  always_ff @(posedge clk) begin
    if (w_capture) r_slot_dp[w_idx] <= ~r_s_cat[0];
  end
`endif

  // A completed mask is published one cycle later; a capture landing on that
  // same edge starts the next frame's mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask       <= '0;
      frame_valid  <= 1'b0;
      frame_digits <= '0;
      frame_err    <= '0;
      overflow     <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
      dp_flags     <= '0;
`endif
    end else begin
      r_mask <= (w_full ? '0 : r_mask) | (w_capture ? w_cap_bit : '0);
      if (w_full) begin
        if (!frame_valid || frame_ready) begin
          frame_valid  <= 1'b1;
          frame_digits <= w_slot_flat;
          frame_err    <= r_slot_err;
`ifdef SEG7_DP_CAPTURE_EN
          dp_flags     <= r_slot_dp;
`endif
        end else begin
          overflow <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

`ifndef SEG7_DP_CAPTURE_EN
  assign dp_flags = '0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder (default parameters).
// Expectations for the decimal-point path follow SEG7_DP_CAPTURE_EN.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  anode;
  logic [7:0]  cathode;
  logic        frame_ready;
  logic        frame_valid;
  logic [31:0] frame_digits;
  logic [7:0]  frame_err;
  logic [7:0]  dp_flags;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  int          fv_cycles = 0;
  logic [31:0] last_digits;
  logic [7:0]  last_err;
  logic [7:0]  last_dp;

  always #5 clk = ~clk;

  seg7_scan_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .anode        (anode),
    .cathode      (cathode),
    .frame_ready  (frame_ready),
    .frame_valid  (frame_valid),
    .frame_digits (frame_digits),
    .frame_err    (frame_err),
    .dp_flags     (dp_flags),
    .overflow     (overflow)
  );

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cycles++;
      last_digits = frame_digits;
      last_err    = frame_err;
      last_dp     = dp_flags;
    end
  end

  function automatic logic [7:0] digit_pat(input int d);
    case (d)
      0: return 8'h03;
      1: return 8'h9F;
      2: return 8'h25;
      3: return 8'h0D;
      4: return 8'h99;
      5: return 8'h49;
      6: return 8'h41;
      7: return 8'h1F;
      8: return 8'h01;
      9: return 8'h09;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic show(input int pos, input logic [7:0] pat, input int cyc);
    anode   = ~(8'b1 << pos);
    cathode = pat;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cyc);
    anode   = 8'hFF;
    cathode = 8'hFF;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    anode = 8'hFF;
    cathode = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    fv_cycles = 0;
  endtask

  // Shows digit p at position p for every position in [lo, hi].
  task automatic scan_range(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) show(p, digit_pat(p), 6);
  endtask

  task automatic test_reset();
    apply_reset();
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", frame_valid); end
    checks++;
    if (frame_digits !== 32'h0) begin failures++; $display("FAIL reset_digits got=%h exp=0", frame_digits); end
    checks++;
    if (frame_err !== 8'h0) begin failures++; $display("FAIL reset_err got=%h exp=0", frame_err); end
    checks++;
    if (dp_flags !== 8'h0) begin failures++; $display("FAIL reset_dp got=%h exp=0", dp_flags); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++;
  endtask

  task automatic test_basic_scan();
    apply_reset();
    frame_ready = 1'b1;
    scan_range(0, 7);
    idle(4);
    if (fv_cycles !== 1) begin failures++; $display("FAIL basic_pulse got=%0d exp=1", fv_cycles); end
    checks++;
    if (last_digits !== 32'h76543210) begin failures++; $display("FAIL basic_digits got=%h exp=76543210", last_digits); end
    checks++;
    if (last_err !== 8'h00) begin failures++; $display("FAIL basic_err got=%h exp=00", last_err); end
    checks++;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL basic_drop got=%b exp=0", frame_valid); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", overflow); end
    checks++;
  endtask

  task automatic test_short_dwell();
    apply_reset();
    scan_range(0, 1);
    show(2, digit_pat(2), 3);
    scan_range(3, 7);
    idle(4);
    if (fv_cycles !== 0) begin failures++; $display("FAIL short_dwell_nocap got=%0d exp=0", fv_cycles); end
    checks++;
    show(2, digit_pat(2), 6);
    idle(4);
    if (fv_cycles !== 1) begin failures++; $display("FAIL short_dwell_recap got=%0d exp=1", fv_cycles); end
    checks++;
    if (last_digits !== 32'h76543210) begin failures++; $display("FAIL short_dwell_digits got=%h exp=76543210", last_digits); end
    checks++;
  endtask

  task automatic test_multi_strobe();
    apply_reset();
    scan_range(1, 7);
    anode   = 8'hFC;
    cathode = digit_pat(8);
    repeat (6) @(posedge clk);
    #1;
    idle(4);
    if (fv_cycles !== 0) begin failures++; $display("FAIL multi_strobe_nocap got=%0d exp=0", fv_cycles); end
    checks++;
    show(0, digit_pat(0), 6);
    idle(4);
    if (fv_cycles !== 1) begin failures++; $display("FAIL multi_strobe_frame got=%0d exp=1", fv_cycles); end
    checks++;
    if (last_digits !== 32'h76543210) begin failures++; $display("FAIL multi_strobe_digits got=%h exp=76543210", last_digits); end
    checks++;
  endtask

  task automatic test_unknown_blank();
    logic [7:0] exp_dp;
`ifdef SEG7_DP_CAPTURE_EN
    exp_dp = 8'h20;
`else
    exp_dp = 8'h00;
`endif
    apply_reset();
    show(0, 8'hFF, 6);
    for (int p = 1; p <= 7; p++) show(p, (p == 5) ? 8'hCA : digit_pat(p), 6);
    idle(4);
    if (fv_cycles !== 1) begin failures++; $display("FAIL unknown_frame got=%0d exp=1", fv_cycles); end
    checks++;
    if (last_digits !== 32'h76F4321B) begin failures++; $display("FAIL unknown_digits got=%h exp=76F4321B", last_digits); end
    checks++;
    if (last_err !== 8'h20) begin failures++; $display("FAIL unknown_err got=%h exp=20", last_err); end
    checks++;
    if (last_dp !== exp_dp) begin failures++; $display("FAIL unknown_dp got=%h exp=%h", last_dp, exp_dp); end
    checks++;
  endtask

  task automatic test_overflow();
    apply_reset();
    frame_ready = 1'b0;
    scan_range(0, 7);
    idle(4);
    if (frame_valid !== 1'b1) begin failures++; $display("FAIL ovf_first_valid got=%b exp=1", frame_valid); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_first_flag got=%b exp=0", overflow); end
    checks++;
    for (int p = 0; p <= 7; p++) show(p, digit_pat(7 - p), 6);
    idle(4);
    if (frame_valid !== 1'b1) begin failures++; $display("FAIL ovf_held_valid got=%b exp=1", frame_valid); end
    checks++;
    if (frame_digits !== 32'h76543210) begin failures++; $display("FAIL ovf_held_digits got=%h exp=76543210", frame_digits); end
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++;
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL ovf_accept_drop got=%b exp=0", frame_valid); end
    checks++;
    idle(2);
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    checks++;
  endtask

  task automatic test_dp_and_async_reset();
    logic [31:0] exp_digits;
    logic [7:0]  exp_err;
    logic [7:0]  exp_dp;
`ifdef SEG7_DP_CAPTURE_EN
    exp_digits = 32'h76543220;
    exp_err    = 8'h00;
    exp_dp     = 8'h02;
`else
    exp_digits = 32'h765432F0;
    exp_err    = 8'h02;
    exp_dp     = 8'h00;
`endif
    apply_reset();
    frame_ready = 1'b1;
    for (int p = 0; p <= 7; p++) show(p, (p == 1) ? 8'h24 : digit_pat(p), 6);
    idle(4);
    if (last_digits !== exp_digits) begin failures++; $display("FAIL dp_digits got=%h exp=%h", last_digits, exp_digits); end
    checks++;
    if (last_err !== exp_err) begin failures++; $display("FAIL dp_err got=%h exp=%h", last_err, exp_err); end
    checks++;
    if (last_dp !== exp_dp) begin failures++; $display("FAIL dp_flags got=%h exp=%h", last_dp, exp_dp); end
    checks++;

    // Hold a frame, overflow on a second, capture half of a third, then reset mid-dwell.
    frame_ready = 1'b0;
    scan_range(0, 7);
    scan_range(0, 7);
    scan_range(0, 3);
    show(4, digit_pat(4), 2);
    #2;
    reset = 1'b1;
    #1;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", frame_valid); end
    checks++;
    if (frame_digits !== 32'h0) begin failures++; $display("FAIL areset_digits got=%h exp=0", frame_digits); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL areset_ovf got=%b exp=0", overflow); end
    checks++;
    if (dp_flags !== 8'h0) begin failures++; $display("FAIL areset_dp got=%h exp=0", dp_flags); end
    checks++;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    fv_cycles   = 0;
    frame_ready = 1'b1;
    scan_range(4, 7);
    idle(4);
    if (fv_cycles !== 0) begin failures++; $display("FAIL areset_partial got=%0d exp=0", fv_cycles); end
    checks++;
    scan_range(0, 3);
    idle(4);
    if (fv_cycles !== 1) begin failures++; $display("FAIL areset_refill got=%0d exp=1", fv_cycles); end
    checks++;
    if (last_digits !== 32'h76543210) begin failures++; $display("FAIL areset_digits_after got=%h exp=76543210", last_digits); end
    checks++;
  endtask

  initial begin
    reset       = 1'b1;
    anode       = 8'hFF;
    cathode     = 8'hFF;
    frame_ready = 1'b1;
    test_reset();
    test_basic_scan();
    test_short_dwell();
    test_multi_strobe();
    test_unknown_blank();
    test_overflow();
    test_dp_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
